// File: rtl/bus_cmd_master_pkg.sv
// bus_cmd_master_pkg
// Shared definitions for the byte-stream bus command master: opcode bit
// positions, the FSM state encoding and the transfer count used when the
// length byte is zero.
package bus_cmd_master_pkg;

  localparam int OP_READ_BIT    = 7;  // 1 = read command, 0 = write command
  localparam int OP_FIXADDR_BIT = 6;  // 1 = hold address (only with FIXADDR build)

  // A length byte of zero encodes the maximum burst of 256 transfers.
  localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR       = 3'd1,
    LEN        = 3'd2,
    WR_DATA    = 3'd3,
    RD_ISSUE   = 3'd4,
    RD_CAPTURE = 3'd5,
    RD_HOLD    = 3'd6
  } state_t;

endpackage

// File: rtl/bus_cmd_master.sv
// bus_cmd_master
// Parses read/write commands from a host byte stream and drives the
// single-byte register bus. Command = opcode, ADDR_BYTES address bytes
// (MSB first), length byte L (0 means 256), then L data bytes for writes.
// Read data is returned one byte at a time on the RSP stream.
//
// Optional build macro: BUS_CMD_MASTER_FIXADDR_EN -- when defined, opcode
// bit 6 = 1 keeps the address constant for the whole command.
//
// Ports:
//   BUS_CLK, BUS_RST          clock, asynchronous active-high reset
//   CMD_DATA/VALID/READY      host command byte stream (input)
//   RSP_DATA/VALID/READY      read-back byte stream (output)
//   BUS_ADD, BUS_WDATA        bus address and write data
//   BUS_RD, BUS_WR            one-cycle read / write strobes
//   BUS_RDATA                 OR-ed responder data, valid cycle after BUS_RD
//   BUSY                      high whenever the FSM is not IDLE
//   o_dbg_state               current FSM state (debug observation)
//
// Handshake: a byte moves on a stream only in a cycle where both VALID and
// READY are high at the rising edge; a VALID source holds its data until then.
module bus_cmd_master
  import bus_cmd_master_pkg::*;
#(
  parameter int ABUSWIDTH = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [7:0]           CMD_DATA,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  output logic [7:0]           RSP_DATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  output logic [7:0]           BUS_WDATA,
  output logic                 BUS_RD,
  output logic                 BUS_WR,
  input  logic [7:0]           BUS_RDATA,
  output logic                 BUSY,
  output logic [2:0]           o_dbg_state
);

  localparam int ADDR_BYTES = (ABUSWIDTH + 7) / 8;

  state_t r_state;
  state_t w_next;

  logic [ABUSWIDTH-1:0] r_addr;     // address of the next transfer
  logic [ABUSWIDTH-1:0] r_bus_add;  // address presented on the bus
  logic [7:0]           r_wdata;
  logic                 r_wr;
  logic [7:0]           r_rsp_data;
  logic                 r_rsp_valid;
  logic [8:0]           r_cnt;      // transfers remaining
  logic [7:0]           r_abyte;    // address bytes remaining minus one
  logic                 r_is_read;
  logic                 r_fix;

  logic                 w_cmd_ready;
  logic                 w_cmd_fire;
  logic                 w_rsp_fire;
  logic                 w_busy;
  logic                 w_bus_rd;
  logic [ABUSWIDTH+7:0] w_addr_shift;
  logic [ABUSWIDTH-1:0] w_addr_next;

  // CMD_READY is forced low while reset is held.
  assign CMD_READY    = w_cmd_ready & ~BUS_RST;
  assign w_cmd_fire   = CMD_VALID & CMD_READY;
  assign w_rsp_fire   = r_rsp_valid & RSP_READY;
  // Shifting the whole address byte in and keeping the low bits drops any
  // address bits beyond ABUSWIDTH.
  assign w_addr_shift = {r_addr, CMD_DATA};
  assign w_addr_next  = r_fix ? r_addr : r_addr + ABUSWIDTH'(1);

  assign RSP_DATA    = r_rsp_data;
  assign RSP_VALID   = r_rsp_valid;
  assign BUS_ADD     = r_bus_add;
  assign BUS_WDATA   = r_wdata;
  assign BUS_WR      = r_wr;
  assign BUS_RD      = w_bus_rd;
  assign BUSY        = w_busy;
  assign o_dbg_state = r_state;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_bus_rd    = 1'b0;
    w_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_fire) w_next = ADDR;
      end
      ADDR: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_fire && r_abyte == 8'd0) w_next = LEN;
      end
      LEN: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_fire) w_next = r_is_read ? RD_ISSUE : WR_DATA;
      end
      WR_DATA: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_fire && r_cnt == 9'd1) w_next = IDLE;
      end
      RD_ISSUE: begin
        w_bus_rd = 1'b1;
        w_next   = RD_CAPTURE;
      end
      RD_CAPTURE: w_next = RD_HOLD;
      RD_HOLD: begin
        if (w_rsp_fire) w_next = (r_cnt == 9'd1) ? IDLE : RD_ISSUE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      r_addr      <= '0;
      r_bus_add   <= '0;
      r_wdata     <= 8'h00;
      r_wr        <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_cnt       <= 9'd0;
      r_abyte     <= 8'd0;
      r_is_read   <= 1'b0;
      r_fix       <= 1'b0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        IDLE: if (w_cmd_fire) begin
          r_is_read <= CMD_DATA[OP_READ_BIT];
`ifdef BUS_CMD_MASTER_FIXADDR_EN
          r_fix     <= CMD_DATA[OP_FIXADDR_BIT];
`else
          r_fix     <= 1'b0;
`endif
          r_abyte   <= 8'(ADDR_BYTES - 1);
        end
        ADDR: if (w_cmd_fire) begin
          r_addr  <= w_addr_shift[ABUSWIDTH-1:0];
          r_abyte <= r_abyte - 8'd1;
        end
        LEN: if (w_cmd_fire) begin
          r_cnt <= (CMD_DATA == 8'h00) ? LEN_ZERO_COUNT : {1'b0, CMD_DATA};
          // Reads present the first address together with the RD_ISSUE cycle.
          if (r_is_read) begin
            r_bus_add <= r_addr;
            r_addr    <= w_addr_next;
          end
        end
        WR_DATA: if (w_cmd_fire) begin
          r_bus_add <= r_addr;
          r_wdata   <= CMD_DATA;
          r_wr      <= 1'b1;
          r_addr    <= w_addr_next;
          r_cnt     <= r_cnt - 9'd1;
        end
        RD_CAPTURE: begin
          r_rsp_data  <= BUS_RDATA;
          r_rsp_valid <= 1'b1;
        end
        RD_HOLD: if (w_rsp_fire) begin
          r_rsp_valid <= 1'b0;
          r_cnt       <= r_cnt - 9'd1;
          if (r_cnt != 9'd1) begin
            r_bus_add <= r_addr;
            r_addr    <= w_addr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master
// Directed bench for bus_cmd_master (ABUSWIDTH=16). A command-level model
// turns each command into the list of bus writes, bus reads and response
// bytes it must produce; a per-cycle monitor compares the DUT against it.
// Honours BUS_CMD_MASTER_FIXADDR_EN in the model.
module tb_bus_cmd_master;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic [7:0]  CMD_DATA;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [7:0]  RSP_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_WDATA;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  BUS_RDATA;
  logic        BUSY;
  logic [2:0]  dbg_state;

  bus_cmd_master #(.ABUSWIDTH(16)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST),
    .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .BUS_ADD(BUS_ADD), .BUS_WDATA(BUS_WDATA), .BUS_RD(BUS_RD), .BUS_WR(BUS_WR),
    .BUS_RDATA(BUS_RDATA), .BUSY(BUSY), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 BUS_CLK = ~BUS_CLK;

  // Responder: returns the low address byte, registered, so it is valid in
  // the cycle after BUS_RD; idles at zero on the OR-ed bus.
  always @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) BUS_RDATA <= 8'h00;
    else         BUS_RDATA <= BUS_RD ? BUS_ADD[7:0] : 8'h00;
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;

  logic [23:0] exp_wr_q[$];   // {addr, data}
  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_rsp_q[$];
  logic [15:0] rd_log[$];
  logic [7:0]  wbytes[$];

  int          wr_count = 0, rd_count = 0, rsp_count = 0;
  logic [15:0] last_wr_add;
  logic [7:0]  last_wr_data;
  logic [7:0]  last_rsp;
  logic        hold_prev = 1'b0;
  logic [7:0]  hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge BUS_CLK) begin
    if (BUS_RST !== 1'b0) begin
      hold_prev = 1'b0;
    end else begin
      logic [23:0] e;
      chk("strobe_excl", {31'd0, BUS_RD & BUS_WR}, 32'd0);
      if (BUS_WR) begin
        wr_count++;
        last_wr_add  = BUS_ADD;
        last_wr_data = BUS_WDATA;
        if (exp_wr_q.size() == 0) chk("unexpected_wr", {16'd0, BUS_ADD}, 32'hFFFF_FFFF);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", {16'd0, BUS_ADD}, {16'd0, e[23:8]});
          chk("wr_data", {24'd0, BUS_WDATA}, {24'd0, e[7:0]});
        end
      end
      if (BUS_RD) begin
        rd_count++;
        rd_log.push_back(BUS_ADD);
        if (exp_rd_q.size() == 0) chk("unexpected_rd", {16'd0, BUS_ADD}, 32'hFFFF_FFFF);
        else chk("rd_addr", {16'd0, BUS_ADD}, {16'd0, exp_rd_q.pop_front()});
      end
      if (hold_prev) chk("rsp_hold", {23'd0, RSP_VALID, RSP_DATA}, {23'd0, 1'b1, hold_data});
      if (RSP_VALID && RSP_READY) begin
        rsp_count++;
        last_rsp = RSP_DATA;
        if (exp_rsp_q.size() == 0) chk("unexpected_rsp", {24'd0, RSP_DATA}, 32'hFFFF_FFFF);
        else chk("rsp_data", {24'd0, RSP_DATA}, {24'd0, exp_rsp_q.pop_front()});
      end
      hold_prev = RSP_VALID && !RSP_READY;
      hold_data = RSP_DATA;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t;
    CMD_DATA  = b;
    CMD_VALID = 1'b1;
    t = 0;
    forever begin
      @(negedge BUS_CLK);
      rdy = CMD_READY;
      @(posedge BUS_CLK);
      #1;
      t++;
      if (rdy) break;
      if (t >= 500) begin
        chk("cmd_accept_timeout", {31'd0, rdy}, 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_quiet();
    for (int t = 0; t < 3000; t++) begin
      @(negedge BUS_CLK);
      if (!BUSY && exp_wr_q.size() == 0 && exp_rd_q.size() == 0 && exp_rsp_q.size() == 0) break;
    end
    chk("quiet_busy", {31'd0, BUSY}, 32'd0);
    chk("quiet_pending", exp_wr_q.size() + exp_rd_q.size() + exp_rsp_q.size(), 32'd0);
    @(posedge BUS_CLK);
    #1;
  endtask

  // Command model: expand the command into the transfers it must cause.
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] base,
                         input logic [7:0] len, input bit wait_done);
    int          n;
    bit          fix;
    logic [15:0] a;
    n   = (len == 8'h00) ? 256 : int'(len);
    fix = 1'b0;
`ifdef BUS_CMD_MASTER_FIXADDR_EN
    fix = op[6];
`endif
    for (int i = 0; i < n; i++) begin
      a = fix ? base : base + 16'(i);
      if (op[7]) begin
        exp_rd_q.push_back(a);
        exp_rsp_q.push_back(a[7:0]);
      end else begin
        exp_wr_q.push_back({a, wbytes[i]});
      end
    end
    send_byte(op);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    send_byte(len);
    if (!op[7]) for (int i = 0; i < n; i++) send_byte(wbytes[i]);
    CMD_VALID = 1'b0;
    if (wait_done) wait_quiet();
  endtask

  // ---------------- stimulus ----------------
  int base_wr, base_rd, base_rsp;

  initial begin
    BUS_RST   = 1'b1;
    CMD_VALID = 1'b0;
    CMD_DATA  = 8'h00;
    RSP_READY = 1'b1;
    repeat (3) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    chk("rst_outputs", {7'd0, RSP_VALID, RSP_DATA, BUS_WDATA, BUS_RD, BUS_WR, BUSY}, 32'd0);
    chk("rst_bus_add", {16'd0, BUS_ADD}, 32'd0);
    @(posedge BUS_CLK);
    #1 BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    chk("cmd_ready_after_rst", {31'd0, CMD_READY}, 32'd1);
    @(posedge BUS_CLK);
    #1;

    // Two-byte write at 0x1003.
    base_wr = wr_count; base_rd = rd_count;
    wbytes = '{8'hAA, 8'h55};
    run_cmd(8'h00, 16'h1003, 8'h02, 1'b1);
    chk("w1_count", wr_count - base_wr, 32'd2);
    chk("w1_last_add", {16'd0, last_wr_add}, 32'h1004);
    chk("w1_last_data", {24'd0, last_wr_data}, 32'h55);
    chk("w1_no_rd", rd_count - base_rd, 32'd0);
    chk("w1_busy", {31'd0, BUSY}, 32'd0);

    // Three-byte read at 0x0001, consumer always ready.
    base_rd = rd_count; base_rsp = rsp_count;
    run_cmd(8'h80, 16'h0001, 8'h03, 1'b1);
    chk("r1_rd_count", rd_count - base_rd, 32'd3);
    chk("r1_rsp_count", rsp_count - base_rsp, 32'd3);
    chk("r1_last_rsp", {24'd0, last_rsp}, 32'h03);

    // Same read with the consumer stalled for 10 cycles.
    base_rd = rd_count;
    RSP_READY = 1'b0;
    run_cmd(8'h80, 16'h0001, 8'h03, 1'b0);
    repeat (10) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    chk("bp_one_rd", rd_count - base_rd, 32'd1);
    chk("bp_rsp", {23'd0, RSP_VALID, RSP_DATA}, {23'd0, 1'b1, 8'h01});
    chk("bp_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    @(posedge BUS_CLK);
    #1 RSP_READY = 1'b1;
    wait_quiet();
    chk("bp_rd_total", rd_count - base_rd, 32'd3);

    // Length 0 (256) read starting at 0xFFFF wraps through 0x0000.
    rd_log.delete();
    run_cmd(8'h80, 16'hFFFF, 8'h00, 1'b1);
    chk("wrap_count", rd_log.size(), 32'd256);
    chk("wrap_first", {16'd0, (rd_log.size() > 0) ? rd_log[0] : 16'hDEAD}, 32'hFFFF);
    chk("wrap_second", {16'd0, (rd_log.size() > 1) ? rd_log[1] : 16'hDEAD}, 32'h0000);
    chk("wrap_last", {16'd0, (rd_log.size() > 255) ? rd_log[255] : 16'hDEAD}, 32'h00FE);

    // Opcode bit 6 set: fixed address only when the feature is built in.
    base_wr = wr_count;
    wbytes = '{8'h11, 8'h22, 8'h33};
    run_cmd(8'h40, 16'h0005, 8'h03, 1'b1);
    chk("fix_count", wr_count - base_wr, 32'd3);
`ifdef BUS_CMD_MASTER_FIXADDR_EN
    chk("fix_last_add", {16'd0, last_wr_add}, 32'h0005);
`else
    chk("fix_last_add", {16'd0, last_wr_add}, 32'h0007);
`endif

    // Reset while waiting for the response handshake.
    RSP_READY = 1'b0;
    run_cmd(8'h80, 16'h0020, 8'h02, 1'b0);
    for (int t = 0; t < 50; t++) begin
      @(negedge BUS_CLK);
      if (RSP_VALID) break;
    end
    chk("pre_rst_valid", {31'd0, RSP_VALID}, 32'd1);
    @(posedge BUS_CLK);
    #1 BUS_RST = 1'b1;
    #1;
    chk("midrst_outputs", {29'd0, RSP_VALID, BUS_RD, BUSY}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, CMD_READY}, 32'd0);
    exp_rd_q.delete();
    exp_rsp_q.delete();
    repeat (2) @(posedge BUS_CLK);
    #1 BUS_RST = 1'b0;
    RSP_READY = 1'b1;
    base_wr = wr_count;
    wbytes = '{8'hC3};
    run_cmd(8'h00, 16'h0030, 8'h01, 1'b1);
    chk("post_rst_wr_count", wr_count - base_wr, 32'd1);
    chk("post_rst_wr", {8'd0, last_wr_add, last_wr_data}, 32'h0030C3);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
